// File: rtl/ex_stage_fwd.sv
// Execute stage with EX/MEM and MEM/WB operand forwarding, ALU, branch target and ready/valid output.
// Define EX_MUL_EN to add the iterative shift-add multiplier (funct 0x18); otherwise 0x18 decodes as ADD.
module ex_stage_fwd #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [1:0]        wb_in,
    input  logic [2:0]        mem_in,
    input  logic [3:0]        ex_in,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] imm,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic              exm_we,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              mwb_we,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [1:0]        wb_out,
    output logic              branch,
    output logic              memread,
    output logic              memwrite,
    output logic [DATA_W-1:0] br_target,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic              zero,
    output logic [REG_AW-1:0] dst_out
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mul_res;
    logic              is_mul;
    logic              idle;
    logic              capture;
    logic              mul_done;

    // Forwarding: the younger EX/MEM result wins over MEM/WB; register 0 is never forwarded.
    always_comb begin : fwd_mux
        op_a = rd1;
        if (exm_we && (exm_rd == rs) && (rs != '0))
            op_a = exm_data;
        else if (mwb_we && (mwb_rd == rs) && (rs != '0))
            op_a = mwb_data;
        fwd_b = rd2;
        if (exm_we && (exm_rd == rt) && (rt != '0))
            fwd_b = exm_data;
        else if (mwb_we && (mwb_rd == rt) && (rt != '0))
            fwd_b = mwb_data;
        op_b = ex_in[0] ? imm : fwd_b;
    end

    always_comb begin : alu
        alu_res = op_a + op_b;
        is_mul  = 1'b0;
        case (ex_in[3:2])
            2'b01: alu_res = op_a - op_b;
            2'b11: alu_res = op_a | op_b;
            2'b10: begin
                case (imm[5:0])
                    6'h22:   alu_res = op_a - op_b;
                    6'h24:   alu_res = op_a & op_b;
                    6'h25:   alu_res = op_a | op_b;
                    6'h2A:   alu_res = DATA_W'($signed(op_a) < $signed(op_b));
`ifdef EX_MUL_EN
                    6'h18:   is_mul  = 1'b1;
`endif
                    default: alu_res = op_a + op_b;
                endcase
            end
            default: alu_res = op_a + op_b;
        endcase
    end

    assign in_ready = idle && !(out_valid && !out_ready);
    assign capture  = in_valid && in_ready && !flush;

`ifdef EX_MUL_EN
    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic {IDLE, MUL} state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] prod;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin : state_next
        state_nx = state;
        mul_done = 1'b0;
        case (state)
            IDLE: if (capture && is_mul) state_nx = MUL;
            MUL: begin
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    state_nx = IDLE;
                    mul_done = !flush;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    assign idle    = (state == IDLE);
    assign mul_res = mplier[0] ? prod + mcand : prod;

    // One shift-add step per cycle; only the low DATA_W product bits are kept.
    always_ff @(posedge clk or negedge rst) begin : mul_dp
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else if (capture && is_mul) begin
            mcand  <= op_a;
            mplier <= op_b;
            prod   <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            prod   <= mul_res;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end
`else
    assign idle     = 1'b1;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
`endif

    // Controls and side results load at capture; a multiply publishes its result on completion.
    always_ff @(posedge clk or negedge rst) begin : out_regs
        if (!rst) begin
            out_valid <= 1'b0;
            wb_out    <= '0;
            branch    <= 1'b0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            br_target <= '0;
            alu_out   <= '0;
            rd2_out   <= '0;
            zero      <= 1'b0;
            dst_out   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            wb_out    <= wb_in;
            branch    <= mem_in[2];
            memread   <= mem_in[1];
            memwrite  <= mem_in[0];
            br_target <= npc + (imm << 2);
            rd2_out   <= fwd_b;
            dst_out   <= ex_in[1] ? rd : rt;
            if (is_mul) begin
                out_valid <= 1'b0;
            end else begin
                alu_out   <= alu_res;
                zero      <= (alu_res == '0);
                out_valid <= 1'b1;
            end
        end else if (mul_done) begin
            alu_out   <= mul_res;
            zero      <= (mul_res == '0);
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_fwd.sv
// Randomized bench for ex_stage_fwd against a cycle-level arithmetic reference model.
// Multiply checks are compiled in when EX_MUL_EN is defined.
module tb_ex_stage_fwd;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    typedef struct packed {
        logic [1:0]    wb;
        logic [2:0]    mem;
        logic [3:0]    ex;
        logic [DW-1:0] npc;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic          exm_we;
        logic [AW-1:0] exm_rd;
        logic [DW-1:0] exm_data;
        logic          mwb_we;
        logic [AW-1:0] mwb_rd;
        logic [DW-1:0] mwb_data;
    } bundle_t;

    typedef struct packed {
        logic [1:0]    wb;
        logic          branch;
        logic          memread;
        logic          memwrite;
        logic [DW-1:0] br_target;
        logic [DW-1:0] alu;
        logic [DW-1:0] rd2;
        logic          zero;
        logic [AW-1:0] dst;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic flush = 1'b0;
    logic out_ready = 1'b1;
    bundle_t cur = '0;

    logic          in_ready;
    logic          out_valid;
    logic [1:0]    wb_out;
    logic          branch;
    logic          memread;
    logic          memwrite;
    logic [DW-1:0] br_target;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] rd2_out;
    logic          zero;
    logic [AW-1:0] dst_out;

    int   n_checks = 0;
    int   n_fail = 0;
    int   m_busy = 0;
    bit   m_ov = 1'b0;
    res_t m_out = '0;
    res_t m_pend = '0;

    ex_stage_fwd #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .wb_in(cur.wb), .mem_in(cur.mem), .ex_in(cur.ex),
        .npc(cur.npc), .rd1(cur.rd1), .rd2(cur.rd2), .imm(cur.imm),
        .rs(cur.rs), .rt(cur.rt), .rd(cur.rd),
        .exm_we(cur.exm_we), .exm_rd(cur.exm_rd), .exm_data(cur.exm_data),
        .mwb_we(cur.mwb_we), .mwb_rd(cur.mwb_rd), .mwb_data(cur.mwb_data),
        .out_ready(out_ready), .out_valid(out_valid), .wb_out(wb_out),
        .branch(branch), .memread(memread), .memwrite(memwrite),
        .br_target(br_target), .alu_out(alu_out), .rd2_out(rd2_out),
        .zero(zero), .dst_out(dst_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_fwd(input logic [AW-1:0] r, input logic [DW-1:0] rf);
        if (r == 0) return rf;
        if (cur.exm_we && cur.exm_rd == r) return cur.exm_data;
        if (cur.mwb_we && cur.mwb_rd == r) return cur.mwb_data;
        return rf;
    endfunction

    function automatic longint as_signed(input logic [DW-1:0] v);
        longint x;
        x = longint'(v);
        if (x >= (longint'(1) << (DW - 1))) x = x - (longint'(1) << DW);
        return x;
    endfunction

    task automatic ref_result(output res_t r, output bit mul);
        logic [63:0] a, b, m, res;
        m   = (64'd1 << DW) - 64'd1;
        mul = 1'b0;
        a   = 64'(ref_fwd(cur.rs, cur.rd1));
        r.rd2 = ref_fwd(cur.rt, cur.rd2);
        b   = cur.ex[0] ? 64'(cur.imm) : 64'(r.rd2);
        case (cur.ex[3:2])
            2'd0: res = a + b;
            2'd1: res = a - b;
            2'd3: res = a | b;
            default: begin
                case (cur.imm[5:0])
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h2A: res = (as_signed(DW'(a)) < as_signed(DW'(b))) ? 64'd1 : 64'd0;
`ifdef EX_MUL_EN
                    6'h18: begin res = a * b; mul = 1'b1; end
`endif
                    default: res = a + b;
                endcase
            end
        endcase
        res = res & m;
        r.alu       = DW'(res);
        r.zero      = (res == 64'd0);
        r.br_target = DW'((64'(cur.npc) + 64'(cur.imm) * 64'd4) & m);
        r.wb        = cur.wb;
        r.branch    = cur.mem[2];
        r.memread   = cur.mem[1];
        r.memwrite  = cur.mem[0];
        r.dst       = cur.ex[1] ? cur.rd : cur.rt;
    endtask

    // One clock: check in_ready, advance the model at the edge, then check the outputs.
    task automatic cycle();
        bit   exp_rdy, mul;
        res_t r;
        #1;
        exp_rdy = (m_busy == 0) && !(m_ov && !out_ready);
        check("in_ready", in_ready, exp_rdy);
        ref_result(r, mul);
        @(posedge clk);
        if (flush) begin
            m_ov = 1'b0;
            m_busy = 0;
        end else if (in_valid && exp_rdy) begin
            if (mul) begin m_busy = DW; m_ov = 1'b0; m_pend = r; end
            else     begin m_out = r; m_ov = 1'b1; end
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin m_out = m_pend; m_ov = 1'b1; end
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        #1;
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("alu_out", alu_out, m_out.alu);
            check("zero", zero, m_out.zero);
            check("br_target", br_target, m_out.br_target);
            check("rd2_out", rd2_out, m_out.rd2);
            check("dst_out", dst_out, m_out.dst);
            check("ctrl", {wb_out, branch, memread, memwrite}, {m_out.wb, m_out.branch, m_out.memread, m_out.memwrite});
        end
    endtask

    task automatic check_reset_outs();
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_out", alu_out, 0);
        check("rst_br_target", br_target, 0);
        check("rst_rd2_out", rd2_out, 0);
        check("rst_dst_zero", {dst_out, zero}, 0);
        check("rst_ctrl", {wb_out, branch, memread, memwrite}, 0);
    endtask

    // Reset asserted between edges, observed before any clock edge arrives.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1 check_reset_outs();
        m_ov = 1'b0;
        m_busy = 0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    function automatic bundle_t plain(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bundle_t x;
        x = '0;
        x.rd1 = a; x.rd2 = b;
        x.rs = AW'(1); x.rt = AW'(2); x.rd = AW'(3);
        x.npc = 32'h100; x.mem = 3'b101; x.wb = 2'b10;
        return x;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t   x;
        logic [5:0] ft [0:6];
        ft = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h07};
        x.wb = 2'($urandom); x.mem = 3'($urandom); x.ex = 4'($urandom);
        x.npc = $urandom; x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom;
        if ($urandom_range(0, 3) != 0) x.imm[5:0] = ft[$urandom_range(0, 6)];
        if ($urandom_range(0, 3) == 0) x.rd2 = x.rd1;
        x.rs = AW'($urandom_range(0, 3)); x.rt = AW'($urandom_range(0, 3));
        x.rd = AW'($urandom);
        x.exm_we = 1'($urandom); x.exm_rd = AW'($urandom_range(0, 3)); x.exm_data = $urandom;
        x.mwb_we = 1'($urandom); x.mwb_rd = AW'($urandom_range(0, 3)); x.mwb_data = $urandom;
        return x;
    endfunction

    initial begin
        #3;
        check_reset_outs();
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b1;

        // Plain ADD, no forwarding
        cur = plain(5, 7); in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        check("add_alu", alu_out, 12);
        check("add_zero", zero, 0);
        check("add_valid", out_valid, 1);

        // EX/MEM beats MEM/WB; r0 never forwards
        cur = plain(32'h99, 1); cur.rs = AW'(3); cur.rt = AW'(4);
        cur.exm_we = 1'b1; cur.exm_rd = AW'(3); cur.exm_data = 32'h10;
        cur.mwb_we = 1'b1; cur.mwb_rd = AW'(3); cur.mwb_data = 32'h20;
        cycle();
        check("fwd_exm", alu_out, 32'h11);
        cur.rs = '0; cur.exm_rd = '0; cur.mwb_rd = '0; cur.rd1 = 9;
        cycle();
        check("fwd_r0", alu_out, 10);

        // Backpressure holds outputs and blocks new bundles
        cur = plain(100, 1);
        cycle();
        out_ready = 1'b0; cur = plain(200, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_alu", alu_out, 101);
            check("stall_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        cycle();
        check("release_alu", alu_out, 201);

        // Flush wins over a simultaneous capture
        cur = plain(3, 4); flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_valid", out_valid, 0);

        // Asynchronous reset while holding a valid output
        cur = plain(8, 8); cycle();
        out_ready = 1'b0; in_valid = 1'b0; cycle();
        async_reset();
        out_ready = 1'b1; cycle();

`ifdef EX_MUL_EN
        begin
            int lat;
            in_valid = 1'b1;
            cur = plain(32'hFFFF_FFFF, 2); cur.ex = 4'b1000; cur.imm = 32'h18;
            cycle();
            lat = 1;
            while (!out_valid && lat < 40) begin
                cur = rand_bundle();
                cycle();
                lat++;
            end
            in_valid = 1'b0;
            check("mul_latency", lat, DW + 1);
            check("mul_result", alu_out, 32'hFFFF_FFFE);
            cycle();

            in_valid = 1'b1;
            cur = plain(7, 9); cur.ex = 4'b1000; cur.imm = 32'h18;
            cycle();
            in_valid = 1'b0;
            repeat (9) cycle();
            flush = 1'b1;
            cycle();
            flush = 1'b0;
            check("mul_flush_valid", out_valid, 0);
            check("mul_flush_rdy", in_ready, 1);
            repeat (DW + 3) cycle();

            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            repeat (5) cycle();
            async_reset();
            repeat (DW + 3) cycle();
        end
`else
        in_valid = 1'b1;
        cur = plain(32'hFFFF_FFFF, 2); cur.ex = 4'b1000; cur.imm = 32'h18;
        cycle();
        check("f18_add", alu_out, 1);
        check("f18_valid", out_valid, 1);
`endif

        for (int i = 0; i < 800; i++) begin
            cur       = rand_bundle();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0;
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage_fwd.md
EX_STAGE_FWD -- requirements
Module: ex_stage_fwd

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter REG_AW, default 5, register-specifier width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  ID/EX bundle valid.
REQ-006 SHALL have port in_ready  output  1  stage accepts bundle this cycle.
REQ-007 SHALL have port flush  input  1  kill in-flight and output contents.
REQ-008 SHALL have port wb_in  input  2  WB controls, passed through.
REQ-009 SHALL have port mem_in  input  3  {branch,memread,memwrite} MSB-first, passed through.
REQ-010 SHALL have port ex_in  input  4  [0] alusrc, [1] regdst, [3:2] aluop.
REQ-011 SHALL have ports npc, rd1, rd2, imm  input  DATA_W each  next PC, rs data, rt data, sign-extended immediate.
REQ-012 SHALL have ports rs, rt, rd  input  REG_AW each  source/destination specifiers.
REQ-013 SHALL have ports exm_we, exm_rd, exm_data  input  1/REG_AW/DATA_W  EX/MEM forwarding source.
REQ-014 SHALL have ports mwb_we, mwb_rd, mwb_data  input  1/REG_AW/DATA_W  MEM/WB forwarding source.
REQ-015 SHALL have port out_ready  input  1  downstream accepts output.
REQ-016 SHALL have port out_valid  output  1  registered outputs valid.
REQ-017 SHALL have ports wb_out, branch, memread, memwrite  output  2/1/1/1  registered controls.
REQ-018 SHALL have ports br_target, alu_out, rd2_out  output  DATA_W each  registered npc+(imm<<2), ALU result, forwarded rt data.
REQ-019 SHALL have ports zero, dst_out  output  1/REG_AW  alu result==0, selected destination.

Function
REQ-020 SHALL forward operand A (rs) and B (rt): EX/MEM if exm_we && exm_rd==spec && spec!=0, else MEM/WB under same rule, else rd1/rd2; EX/MEM wins when both match.
REQ-021 SHALL select ALU B = imm when alusrc=1, else forwarded rt; rd2_out = forwarded rt.
REQ-022 SHALL decode aluop: 00 ADD, 01 SUB, 10 by imm[5:0] (0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT signed, 0x18 MUL, other ADD), 11 OR.
REQ-023 SHALL compute all arithmetic modulo 2^DATA_W; SLT yields 1 or 0 zero-extended; br_target drops carry.
REQ-024 SHALL drive in_ready = (state==IDLE) && !(out_valid && !out_ready).
REQ-025 SHALL capture a bundle only on in_valid && in_ready; non-MUL results register next edge (latency 1), out_valid=1.
REQ-026 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-027 SHALL clear out_valid after out_ready && out_valid when no new capture occurs the same edge; capture and drain in one cycle is legal.
REQ-028 SHALL implement FSM IDLE->MUL on MUL capture, MUL iterates DATA_W shift-add cycles, MUL->IDLE loading product low DATA_W bits, out_valid=1; latency DATA_W+1.
REQ-029 SHALL latch operands, controls and dst at MUL capture; later input changes have no effect.
REQ-030 SHALL on flush force out_valid=0 and state=IDLE next edge, discarding any MUL; flush beats simultaneous capture.

Reset
REQ-031 SHALL on rst=0 immediately set state=IDLE, out_valid=0 and every other output register to 0, regardless of clk.
REQ-032 SHALL on reset mid-MUL abandon the operation with no output produced after release.

Configuration
REQ-033 SHALL include the multiplier and MUL state only when EX_MUL_EN is defined.
REQ-034 SHALL without EX_MUL_EN decode funct 0x18 as ADD with latency 1 and never leave IDLE.

Verification
REQ-035 SHALL bench: ADD rd1=5, rd2=7, no forwarding -> alu_out=12, zero=0, out_valid one cycle after capture.
REQ-036 SHALL bench: rs=3 with exm_rd=3, mwb_rd=3, exm_data=0x10, mwb_data=0x20, rd2=1 -> alu_out=0x11; rs=0 with exm_rd=0 -> rd1 used.
REQ-037 SHALL bench (EX_MUL_EN): MUL 0xFFFF_FFFF*2 -> alu_out=0xFFFF_FFFE after 33 cycles, in_ready=0 throughout.
REQ-038 SHALL bench: out_ready=0 for 4 cycles with out_valid=1 -> outputs constant, in_ready=0; release -> next bundle captured.
REQ-039 SHALL bench: flush at MUL cycle 10 -> out_valid stays 0, in_ready=1 next cycle; rst=0 mid-MUL -> all outputs 0 asynchronously.
